// File: rtl/decode_issue_ctrl.sv
// Decode-stage issue FIFO: buffers fetched instructions, classifies the immediate format at enqueue.
// Optional macro DECODE_IMM_EN adds a per-entry sign-extended immediate on out_imm.
module decode_issue_ctrl #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    in_inst,
    input  logic [PC_W-1:0]                in_pc,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_inst,
    output logic [PC_W-1:0]                out_pc,
    output logic [2:0]                     out_imm_sel,
    output logic                           out_illegal,
`ifdef DECODE_IMM_EN
    output logic [31:0]                    out_imm,
`endif
    output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_I    = 3'd1;
    localparam logic [2:0] SEL_S    = 3'd2;
    localparam logic [2:0] SEL_B    = 3'd3;
    localparam logic [2:0] SEL_U    = 3'd4;
    localparam logic [2:0] SEL_J    = 3'd5;

    // Returns {illegal, imm_sel}; opcodes with low bits != 2'b11 never match and fall to illegal.
    function automatic logic [3:0] classify(input logic [6:0] opc);
        logic [3:0] r;
        case (opc)
            7'b0110011:                         r = {1'b0, SEL_NONE};
            7'b0000011, 7'b0010011, 7'b1100111: r = {1'b0, SEL_I};
            7'b0100011:                         r = {1'b0, SEL_S};
            7'b1100011:                         r = {1'b0, SEL_B};
            7'b0110111, 7'b0010111:             r = {1'b0, SEL_U};
            7'b1101111:                         r = {1'b0, SEL_J};
            default:                            r = {1'b1, SEL_NONE};
        endcase
        return r;
    endfunction

`ifdef DECODE_IMM_EN
    function automatic logic signed [31:0] gen_imm(input logic [31:0] i, input logic [2:0] sel);
        logic signed [31:0] r;
        case (sel)
            SEL_I:   r = {{20{i[31]}}, i[31:20]};
            SEL_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
            SEL_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            SEL_U:   r = {i[31:12], 12'b0};
            SEL_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction
`endif

    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push, pop;

    logic [31:0]      inst_mem    [DEPTH];
    logic [PC_W-1:0]  pc_mem      [DEPTH];
    logic [2:0]       sel_mem     [DEPTH];
    logic             illegal_mem [DEPTH];

    // Enqueue-time classification
    logic [3:0]       class_p0;
    logic [2:0]       imm_sel_p0;
    logic             illegal_p0;

    assign class_p0   = classify(in_inst[6:0]);
    assign imm_sel_p0 = class_p0[2:0];
    assign illegal_p0 = class_p0[3];

    assign in_ready  = (count < FULL);
    assign out_valid = (count != '0);
    assign occupancy = count;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage is data only; empty-gating on the read side hides stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr]    <= in_inst;
            pc_mem[wr_ptr]      <= in_pc;
            sel_mem[wr_ptr]     <= imm_sel_p0;
            illegal_mem[wr_ptr] <= illegal_p0;
        end
    end

    assign out_inst    = out_valid ? inst_mem[rd_ptr]    : '0;
    assign out_pc      = out_valid ? pc_mem[rd_ptr]      : '0;
    assign out_imm_sel = out_valid ? sel_mem[rd_ptr]     : '0;
    assign out_illegal = out_valid ? illegal_mem[rd_ptr] : 1'b0;

`ifdef DECODE_IMM_EN
    logic signed [31:0] imm_p0;
    logic [31:0]        imm_mem [DEPTH];

    assign imm_p0 = gen_imm(in_inst, imm_sel_p0);

    always_ff @(posedge clk) begin
        if (push) imm_mem[wr_ptr] <= imm_p0;
    end

    assign out_imm = out_valid ? imm_mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed self-checking bench for decode_issue_ctrl (DEPTH=2, PC_W=32).
module tb_decode_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [2:0]  out_imm_sel;
    logic        out_illegal;
    logic [1:0]  occupancy;
`ifdef DECODE_IMM_EN
    logic [31:0] out_imm;
`endif

    int checks = 0;
    int passes = 0;

    decode_issue_ctrl #(.DEPTH(2), .PC_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_imm_sel(out_imm_sel), .out_illegal(out_illegal),
`ifdef DECODE_IMM_EN
        .out_imm(out_imm),
`endif
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else passes++;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        #12;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_occupancy", {30'b0, occupancy}, 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_imm_sel", {29'b0, out_imm_sel}, 32'd0);
        check("rst_illegal", {31'b0, out_illegal}, 32'd0);
`ifdef DECODE_IMM_EN
        check("rst_out_imm", out_imm, 32'd0);
`endif
        reset = 1'b0;
        tick();
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        // Fill two entries, then reset asynchronously mid-cycle
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h40;
        tick();
        in_inst = 32'h00112223; in_pc = 32'h44;
        tick();
        in_valid = 1'b0;
        check("rst_pre_occ", {30'b0, occupancy}, 32'd2);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_valid", {31'b0, out_valid}, 32'd0);
        check("rst_mid_occ", {30'b0, occupancy}, 32'd0);
        check("rst_mid_inst", out_inst, 32'd0);
        #3 reset = 1'b0;
        tick();
        check("rst_rel_ready", {31'b0, in_ready}, 32'd1);
        check("rst_rel_valid", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic test_stream();
        logic [31:0] insts [3];
        logic [2:0]  sels  [3];
        insts[0] = 32'h00500093; sels[0] = 3'd1;
        insts[1] = 32'h00112223; sels[1] = 3'd2;
        insts[2] = 32'hFE0008E3; sels[2] = 3'd3;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_inst = insts[k]; in_pc = 32'h100 + 32'(4 * k);
            tick();
            check("stream_valid", {31'b0, out_valid}, 32'd1);
            check("stream_inst", out_inst, insts[k]);
            check("stream_pc", out_pc, 32'h100 + 32'(4 * k));
            check("stream_sel", {29'b0, out_imm_sel}, {29'b0, sels[k]});
            check("stream_occ", {30'b0, occupancy}, 32'd1);
            check("stream_ready", {31'b0, in_ready}, 32'd1);
`ifdef DECODE_IMM_EN
            if (k == 1) check("stream_imm_s", out_imm, 32'd4);
`endif
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain_occ", {30'b0, occupancy}, 32'd0);
        check("stream_drain_inst", out_inst, 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00100113; in_pc = 32'h200;
        tick();
        check("bp_occ1", {30'b0, occupancy}, 32'd1);
        check("bp_ready1", {31'b0, in_ready}, 32'd1);
        in_inst = 32'h00200193; in_pc = 32'h204;
        tick();
        check("bp_occ2", {30'b0, occupancy}, 32'd2);
        check("bp_ready2", {31'b0, in_ready}, 32'd0);
        check("bp_head", out_inst, 32'h00100113);
        in_inst = 32'h00300213; in_pc = 32'h208;
        tick();
        check("bp_hold_occ", {30'b0, occupancy}, 32'd2);
        check("bp_hold_inst", out_inst, 32'h00100113);
        check("bp_hold_pc", out_pc, 32'h200);
        // Full: pop alone this cycle, third instruction still waiting
        out_ready = 1'b1;
        tick();
        check("bp_rel_occ", {30'b0, occupancy}, 32'd1);
        check("bp_rel_inst", out_inst, 32'h00200193);
        check("bp_rel_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check("bp_third_inst", out_inst, 32'h00300213);
        check("bp_third_pc", out_pc, 32'h208);
        check("bp_third_occ", {30'b0, occupancy}, 32'd1);
        in_valid = 1'b0;
        tick();
        check("bp_empty_occ", {30'b0, occupancy}, 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00000033; in_pc = 32'h300;
        tick();
        in_inst = 32'h00000013; in_pc = 32'h304;
        tick();
        check("fl_pre_occ", {30'b0, occupancy}, 32'd2);
        flush = 1'b1; out_ready = 1'b1; in_inst = 32'h00000017; in_pc = 32'h308;
        tick();
        check("fl_occ", {30'b0, occupancy}, 32'd0);
        check("fl_valid", {31'b0, out_valid}, 32'd0);
        check("fl_ready_during", {31'b0, in_ready}, 32'd1);
        // Empty, flush still high: the offered push must be dropped
        tick();
        check("fl_nopush_occ", {30'b0, occupancy}, 32'd0);
        // One entry held, flush with concurrent push and pop
        flush = 1'b0; out_ready = 1'b0; in_inst = 32'h00000037; in_pc = 32'h310;
        tick();
        check("fl_one_occ", {30'b0, occupancy}, 32'd1);
        flush = 1'b1; out_ready = 1'b1; in_inst = 32'h0000006F; in_pc = 32'h314;
        tick();
        check("fl_one_after", {30'b0, occupancy}, 32'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        check("fl_post_valid", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic test_illegal();
        logic [31:0] insts [5];
        logic [2:0]  sels  [5];
        logic        ills  [5];
        insts[0] = 32'h00000000; sels[0] = 3'd0; ills[0] = 1'b1;
        insts[1] = 32'h0000007F; sels[1] = 3'd0; ills[1] = 1'b1;
        insts[2] = 32'h000000EF; sels[2] = 3'd5; ills[2] = 1'b0;
        insts[3] = 32'h00000033; sels[3] = 3'd0; ills[3] = 1'b0;
        insts[4] = 32'h00000017; sels[4] = 3'd4; ills[4] = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_inst = insts[k]; in_pc = 32'h400 + 32'(4 * k);
            tick();
            check("ill_valid", {31'b0, out_valid}, 32'd1);
            check("ill_sel", {29'b0, out_imm_sel}, {29'b0, sels[k]});
            check("ill_flag", {31'b0, out_illegal}, {31'b0, ills[k]});
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
    endtask

`ifdef DECODE_IMM_EN
    task automatic test_imm();
        logic [31:0] insts [4];
        logic [31:0] imms  [4];
        insts[0] = 32'hFFF00093; imms[0] = 32'hFFFFFFFF;
        insts[1] = 32'h12345037; imms[1] = 32'h12345000;
        insts[2] = 32'hFE0008E3; imms[2] = 32'hFFFFFFF0; // B-format offset -16
        insts[3] = 32'h0000007F; imms[3] = 32'h00000000;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_inst = insts[k]; in_pc = 32'h500 + 32'(4 * k);
            tick();
            check("imm_value", out_imm, imms[k]);
        end
        in_valid = 1'b0;
        tick();
        check("imm_empty", out_imm, 32'd0);
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_illegal();
`ifdef DECODE_IMM_EN
        test_imm();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
